// File: rtl/jtag_chain_pkg.sv
// jtag_chain_pkg: shared opcodes, status-bit indices, FSM states and command strobes for the JTAG burst chain.
package jtag_chain_pkg;
  localparam int OP_ADDR   = 1;
  localparam int OP_BE     = 2;
  localparam int OP_SIZE   = 3;
  localparam int OP_WRITE  = 8;
  localparam int OP_READ   = 9;
  localparam int OP_ACK    = 10;
  localparam int OP_CLRERR = 14;
  localparam int OP_ABORT  = 15;
  localparam int ST_ADDR_V = 0;
  localparam int ST_BE_V   = 1;
  localparam int ST_SIZE_V = 2;
  localparam int ST_WBUSY  = 3;
  localparam int ST_RBUSY  = 4;
  localparam int ST_RDV    = 5;
  localparam int ST_ERR    = 6;
  localparam int ST_PEND   = 7;
  typedef enum logic [3:0] {
    IDLE, W_FILL, W_WAIT_SW, W_SWITCH, W_LAUNCH,
    R_LAUNCH, R_WAIT_SW, R_SWITCH, R_ASK, R_STORE, R_PRESENT
  } state_e;
  typedef struct packed {
    logic addr;
    logic be;
    logic size;
    logic wr;
    logic rd;
    logic ack;
    logic clrerr;
    logic abort;
  } cmd_t;
endpackage

// File: rtl/jtag_cmd_shifter.sv
// jtag_cmd_shifter: JTAG shift/capture register with opcode decode into one-cycle command strobes.
module jtag_cmd_shifter
  import jtag_chain_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tdi_i,
  input  logic              shift_i,
  input  logic              update_i,
  input  logic              ce_i,
  input  logic              more_i,
  input  logic [7:0]        status_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              tdo_o,
  output logic              shifted_out_o,
  output logic [DATA_W-1:0] payload_o,
  output cmd_t              cmd_o
);
  localparam int SR_W = DATA_W + OPC_W;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [OPC_W-1:0] opc;
  assign opc = sr_q[OPC_W-1:0];
  assign tdo_o = sr_q[0];
  assign payload_o = sr_q[SR_W-1:OPC_W];
  assign shifted_out_o = ce_i && !shift_i && status_i[ST_RDV];
  // Read data is tagged with all-ones above the "more" flag so the host can tell it from status.
  always_comb begin
    sr_d = sr_q;
    if (ce_i && shift_i) sr_d = {tdi_i, sr_q[SR_W-1:1]};
    else if (ce_i) sr_d = status_i[ST_RDV] ? {{(OPC_W-1){1'b1}}, more_i, rdata_i} : SR_W'(status_i);
  end
  always_comb begin
    cmd_o.addr   = update_i && opc == OPC_W'(OP_ADDR);
    cmd_o.be     = update_i && opc == OPC_W'(OP_BE);
    cmd_o.size   = update_i && opc == OPC_W'(OP_SIZE);
    cmd_o.wr     = update_i && opc == OPC_W'(OP_WRITE);
    cmd_o.rd     = update_i && opc == OPC_W'(OP_READ);
    cmd_o.ack    = update_i && opc == OPC_W'(OP_ACK);
    cmd_o.clrerr = update_i && opc == OPC_W'(OP_CLRERR);
    cmd_o.abort  = update_i && opc == OPC_W'(OP_ABORT);
  end
  always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
endmodule

// File: rtl/jtag_burst_chain.sv
// jtag_burst_chain: JTAG-driven burst controller streaming through a ping-pong buffer in DMA-sized chunks.
module jtag_burst_chain
  import jtag_chain_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BUF_DEPTH = 256,
  parameter int BURST_W   = 8,
  parameter int OPC_W     = 4
) (
  input  logic                         JTCK,
  input  logic                         JRST,
  input  logic                         JTDI,
  input  logic                         JSHIFT,
  input  logic                         JUPDATE,
  input  logic                         JCE1,
  output logic                         JTD1,
  output logic [$clog2(BUF_DEPTH):0]   pp_address,
  output logic                         pp_writeEnable,
  output logic [DATA_W-1:0]            pp_dataIn,
  input  logic [DATA_W-1:0]            pp_dataOut,
  output logic                         pp_switch,
  input  logic                         switch_ready,
  output logic [ADDR_W-1:0]            dma_address,
  output logic [DATA_W/8-1:0]          dma_byte_enable,
  output logic [BURST_W-1:0]           dma_burst_size,
  output logic                         dma_data_ready,
  output logic                         dma_readReady,
  output logic [7:0]                   status_reg_out
);
  localparam int PW = $clog2(BUF_DEPTH) + 1;
  localparam int BE_W = DATA_W / 8;
  state_e state_q, state_d;
  logic [7:0] st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d, caddr_q, caddr_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [BURST_W-1:0] size_q, size_d, rem_q, rem_d;
  logic [PW-1:0] ptr_q, ptr_d, chunk_q, chunk_d, rd_chunk;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, payload;
  logic last_q, last_d, shifted_out, wr_ok, rd_ok, busy, launch;
  cmd_t cmd;
  jtag_cmd_shifter #(.DATA_W(DATA_W), .OPC_W(OPC_W)) u_shifter (
    .clk(JTCK), .rst(JRST), .tdi_i(JTDI), .shift_i(JSHIFT), .update_i(JUPDATE), .ce_i(JCE1),
    .more_i(rem_q != '0), .status_i(st_q), .rdata_i(rdata_q), .tdo_o(JTD1),
    .shifted_out_o(shifted_out), .payload_o(payload), .cmd_o(cmd)
  );
  assign busy = st_q[ST_WBUSY] || st_q[ST_RBUSY];
  assign wr_ok = &st_q[2:0] && !st_q[ST_RBUSY] && state_q == IDLE;
  assign rd_ok = &st_q[2:0] && !busy;
  assign rd_chunk = (int'(rem_q) + 1 > BUF_DEPTH) ? PW'(BUF_DEPTH) : PW'(int'(rem_q) + 1);
  assign status_reg_out = st_q;
  always_ff @(posedge JTCK) state_q <= JRST ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = cmd.wr && wr_ok ? W_FILL : cmd.rd && rd_ok ? R_LAUNCH : IDLE;
      W_FILL:    state_d = (rem_q == '0 || ptr_q == PW'(BUF_DEPTH - 1)) ? W_WAIT_SW : IDLE;
      W_WAIT_SW: state_d = switch_ready ? W_SWITCH : W_WAIT_SW;
      W_SWITCH:  state_d = W_LAUNCH;
      W_LAUNCH:  state_d = IDLE;
      R_LAUNCH:  state_d = R_WAIT_SW;
      R_WAIT_SW: state_d = switch_ready ? R_SWITCH : R_WAIT_SW;
      R_SWITCH:  state_d = R_ASK;
      R_ASK:     state_d = R_STORE;
      R_STORE:   state_d = R_PRESENT;
      R_PRESENT: state_d = !shifted_out ? R_PRESENT : rem_q == '0 ? IDLE :
                           ptr_q == chunk_q - 1'b1 ? R_LAUNCH : R_ASK;
      default:   state_d = IDLE;
    endcase
    if (cmd.abort) state_d = IDLE;
  end
  always_comb begin
    pp_writeEnable  = state_q == W_FILL;
    pp_address      = (state_q == W_FILL || state_q == R_ASK) ? ptr_q : '0;
    pp_dataIn       = pp_writeEnable ? wdata_q : '0;
    pp_switch       = state_q == W_SWITCH || state_q == R_SWITCH;
    dma_data_ready  = state_q == W_LAUNCH;
    dma_readReady   = state_q == R_LAUNCH;
    launch          = dma_data_ready || dma_readReady;
    dma_address     = launch ? caddr_q : '0;
    dma_byte_enable = launch ? be_q : '0;
    dma_burst_size  = dma_data_ready ? BURST_W'(ptr_q - 1'b1) :
                      dma_readReady ? BURST_W'(rd_chunk - 1'b1) : '0;
  end
  // FSM-driven updates first, then host commands, so a same-cycle command wins.
  always_comb begin
    st_d = st_q; addr_d = addr_q; caddr_d = caddr_q; be_d = be_q; size_d = size_q;
    rem_d = rem_q; ptr_d = ptr_q; chunk_d = chunk_q; wdata_d = wdata_q; rdata_d = rdata_q; last_d = last_q;
    case (state_q)
      W_FILL: begin
        ptr_d = ptr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        last_d = rem_q == '0;
      end
      W_WAIT_SW: st_d[ST_PEND] = 1'b1;
      W_LAUNCH: begin
        caddr_d = caddr_q + ADDR_W'(int'(ptr_q) * BE_W);
        ptr_d = '0;
        st_d[ST_PEND] = 1'b0;
        if (last_q) st_d[ST_WBUSY] = 1'b0;
      end
      R_LAUNCH: chunk_d = rd_chunk;
      R_STORE: begin
        rdata_d = pp_dataOut;
        st_d[ST_RDV] = 1'b1;
      end
      R_PRESENT: if (shifted_out) begin
        st_d[ST_RDV] = 1'b0;
        if (rem_q == '0) st_d[ST_RBUSY] = 1'b0;
        else begin
          rem_d = rem_q - 1'b1;
          ptr_d = ptr_q == chunk_q - 1'b1 ? '0 : ptr_q + 1'b1;
          if (ptr_q == chunk_q - 1'b1) caddr_d = caddr_q + ADDR_W'(int'(chunk_q) * BE_W);
        end
      end
      default: ;
    endcase
    if (cmd.addr) begin
      if (busy) st_d[ST_ERR] = 1'b1;
      else begin addr_d = ADDR_W'(payload); st_d[ST_ADDR_V] = 1'b1; end
    end
    if (cmd.be) begin
      if (busy) st_d[ST_ERR] = 1'b1;
      else begin be_d = BE_W'(payload); st_d[ST_BE_V] = 1'b1; end
    end
    if (cmd.size) begin
      if (busy) st_d[ST_ERR] = 1'b1;
      else begin size_d = BURST_W'(payload); st_d[ST_SIZE_V] = 1'b1; end
    end
    if (cmd.wr) begin
      if (!wr_ok) st_d[ST_ERR] = 1'b1;
      else begin
        wdata_d = payload;
        st_d[ST_WBUSY] = 1'b1;
        if (!st_q[ST_WBUSY]) begin rem_d = size_q; caddr_d = addr_q; last_d = 1'b0; end
      end
    end
    if (cmd.rd) begin
      if (!rd_ok) st_d[ST_ERR] = 1'b1;
      else begin st_d[ST_RBUSY] = 1'b1; rem_d = size_q; caddr_d = addr_q; ptr_d = '0; end
    end
    if (cmd.ack) st_d[ST_RDV] = 1'b0;
    if (cmd.clrerr) st_d[ST_ERR] = 1'b0;
    if (cmd.abort) begin
      st_d[ST_WBUSY] = 1'b0; st_d[ST_RBUSY] = 1'b0; st_d[ST_RDV] = 1'b0; st_d[ST_PEND] = 1'b0;
      ptr_d = '0;
    end
  end
  always_ff @(posedge JTCK) begin
    if (JRST) begin
      st_q <= '0; addr_q <= '0; caddr_q <= '0; be_q <= '0; size_q <= '0; rem_q <= '0;
      ptr_q <= '0; chunk_q <= '0; wdata_q <= '0; rdata_q <= '0; last_q <= 1'b0;
    end else begin
      st_q <= st_d; addr_q <= addr_d; caddr_q <= caddr_d; be_q <= be_d; size_q <= size_d; rem_q <= rem_d;
      ptr_q <= ptr_d; chunk_q <= chunk_d; wdata_q <= wdata_d; rdata_q <= rdata_d; last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_jtag_burst_chain.sv
// tb_jtag_burst_chain: directed scenario bench for jtag_burst_chain with a 4-word ping-pong half.
module tb_jtag_burst_chain;
  logic JTCK = 1'b0, JRST, JTDI, JSHIFT, JUPDATE, JCE1, JTD1;
  logic [2:0] pp_address;
  logic pp_writeEnable, pp_switch, switch_ready, dma_data_ready, dma_readReady;
  logic [31:0] pp_dataIn, pp_dataOut, dma_address;
  logic [3:0] dma_byte_enable;
  logic [7:0] dma_burst_size, status_reg_out;
  int checks = 0, failures = 0;
  logic [31:0] mem [4];
  logic [2:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [31:0] la_addr [16];
  logic [7:0] la_bs [16];
  logic [3:0] la_be [16];
  logic [31:0] rl_addr [16];
  logic [7:0] rl_bs [16];
  int n_wr = 0, n_sw = 0, n_la = 0, n_rl = 0;

  jtag_burst_chain #(.DATA_W(32), .ADDR_W(32), .BUF_DEPTH(4), .BURST_W(8), .OPC_W(4)) dut (
    .JTCK(JTCK), .JRST(JRST), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE), .JCE1(JCE1), .JTD1(JTD1),
    .pp_address(pp_address), .pp_writeEnable(pp_writeEnable), .pp_dataIn(pp_dataIn), .pp_dataOut(pp_dataOut),
    .pp_switch(pp_switch), .switch_ready(switch_ready), .dma_address(dma_address),
    .dma_byte_enable(dma_byte_enable), .dma_burst_size(dma_burst_size), .dma_data_ready(dma_data_ready),
    .dma_readReady(dma_readReady), .status_reg_out(status_reg_out)
  );

  always #5 JTCK = ~JTCK;
  always @(posedge JTCK) pp_dataOut <= mem[pp_address[1:0]];
  always @(negedge JTCK) begin
    if (pp_writeEnable) begin wr_addr[n_wr % 64] = pp_address; wr_data[n_wr % 64] = pp_dataIn; n_wr++; end
    if (pp_switch) n_sw++;
    if (dma_data_ready) begin
      la_addr[n_la % 16] = dma_address; la_bs[n_la % 16] = dma_burst_size; la_be[n_la % 16] = dma_byte_enable; n_la++;
    end
    if (dma_readReady) begin rl_addr[n_rl % 16] = dma_address; rl_bs[n_rl % 16] = dma_burst_size; n_rl++; end
  end

  task automatic shift_word(input logic [35:0] din, output logic [35:0] dout);
    for (int i = 0; i < 36; i++) begin
      dout[i] = JTD1; JTDI = din[i]; JSHIFT = 1'b1; JCE1 = 1'b1;
      @(negedge JTCK);
    end
    JSHIFT = 1'b0; JCE1 = 1'b0; JTDI = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [31:0] data);
    logic [35:0] d;
    shift_word({data, op}, d);
    JUPDATE = 1'b1; @(negedge JTCK); JUPDATE = 1'b0;
  endtask

  task automatic capture(output logic [35:0] v);
    JCE1 = 1'b1; JSHIFT = 1'b0; @(negedge JTCK); JCE1 = 1'b0;
    shift_word(36'h0, v);
  endtask

  task automatic test_reset();
    logic [35:0] v;
    int bw;
    JRST = 1'b1; repeat (3) @(negedge JTCK); JRST = 1'b0; @(negedge JTCK);
    checks++; if (status_reg_out !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", status_reg_out); end
    checks++; if (JTD1 !== 1'b0) begin failures++; $display("FAIL reset_jtd1 got=%b exp=0", JTD1); end
    checks++;
    if ({pp_address, pp_writeEnable, pp_dataIn, pp_switch, dma_address, dma_byte_enable, dma_burst_size,
         dma_data_ready, dma_readReady} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h/%h/%h exp=0", pp_address, dma_address, dma_burst_size);
    end
    capture(v);
    checks++; if (v !== 36'h0) begin failures++; $display("FAIL reset_capture got=%h exp=0", v); end
    bw = n_wr;
    cmd(4'h8, 32'h55);
    checks++; if (status_reg_out !== 8'h40) begin failures++; $display("FAIL unconfigured_write_err got=%h exp=40", status_reg_out); end
    checks++; if (n_wr != bw) begin failures++; $display("FAIL unconfigured_write_dropped got=%0d exp=0", n_wr - bw); end
    cmd(4'hE, 32'h0);
    checks++; if (status_reg_out !== 8'h00) begin failures++; $display("FAIL clear_err got=%h exp=00", status_reg_out); end
  endtask

  task automatic test_write_burst();
    int bw, bs, bl;
    cmd(4'h1, 32'h1000); cmd(4'h2, 32'hF); cmd(4'h3, 32'd3);
    checks++; if (status_reg_out !== 8'h07) begin failures++; $display("FAIL cfg_status got=%h exp=07", status_reg_out); end
    bw = n_wr; bs = n_sw; bl = n_la;
    for (int i = 0; i < 4; i++) cmd(4'h8, 32'hA0 + i);
    repeat (10) @(negedge JTCK);
    checks++; if (n_wr - bw != 4) begin failures++; $display("FAIL wr_count got=%0d exp=4", n_wr - bw); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[(bw + i) % 64] !== 3'(i) || wr_data[(bw + i) % 64] !== 32'hA0 + i) begin
        failures++; $display("FAIL wr_word%0d got=%h:%h exp=%h:%h", i, wr_addr[(bw + i) % 64], wr_data[(bw + i) % 64], i, 32'hA0 + i);
      end
    end
    checks++; if (n_sw - bs != 1) begin failures++; $display("FAIL wr_switches got=%0d exp=1", n_sw - bs); end
    checks++; if (n_la - bl != 1) begin failures++; $display("FAIL wr_launches got=%0d exp=1", n_la - bl); end
    checks++;
    if (la_addr[bl % 16] !== 32'h1000 || la_bs[bl % 16] !== 8'd3 || la_be[bl % 16] !== 4'hF) begin
      failures++; $display("FAIL wr_launch got=%h/%h/%h exp=1000/03/f", la_addr[bl % 16], la_bs[bl % 16], la_be[bl % 16]);
    end
    checks++; if (status_reg_out !== 8'h07) begin failures++; $display("FAIL wr_done_status got=%h exp=07", status_reg_out); end
  endtask

  task automatic test_split();
    int bw, bs, bl;
    logic [31:0] ea [3];
    logic [7:0] eb [3];
    ea = '{32'h1000, 32'h1010, 32'h1020};
    eb = '{8'd3, 8'd3, 8'd1};
    cmd(4'h3, 32'd9);
    bw = n_wr; bs = n_sw; bl = n_la;
    for (int i = 0; i < 10; i++) cmd(4'h8, 32'h100 + i);
    repeat (10) @(negedge JTCK);
    checks++; if (n_wr - bw != 10) begin failures++; $display("FAIL split_wr_count got=%0d exp=10", n_wr - bw); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[(bw + i) % 64] !== 3'(i % 4) || wr_data[(bw + i) % 64] !== 32'h100 + i) begin
        failures++; $display("FAIL split_word%0d got=%h:%h exp=%h:%h", i, wr_addr[(bw + i) % 64], wr_data[(bw + i) % 64], i % 4, 32'h100 + i);
      end
    end
    checks++; if (n_sw - bs != 3) begin failures++; $display("FAIL split_switches got=%0d exp=3", n_sw - bs); end
    checks++; if (n_la - bl != 3) begin failures++; $display("FAIL split_launches got=%0d exp=3", n_la - bl); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (la_addr[(bl + i) % 16] !== ea[i] || la_bs[(bl + i) % 16] !== eb[i]) begin
        failures++; $display("FAIL split_launch%0d got=%h/%h exp=%h/%h", i, la_addr[(bl + i) % 16], la_bs[(bl + i) % 16], ea[i], eb[i]);
      end
    end
    checks++; if (status_reg_out !== 8'h07) begin failures++; $display("FAIL split_status got=%h exp=07", status_reg_out); end
  endtask

  task automatic test_read();
    logic [35:0] v;
    int br;
    mem[0] = 32'h11; mem[1] = 32'h22;
    cmd(4'h3, 32'd1);
    br = n_rl;
    cmd(4'h9, 32'h0);
    repeat (8) @(negedge JTCK);
    checks++; if (n_rl - br != 1) begin failures++; $display("FAIL rd_launches got=%0d exp=1", n_rl - br); end
    checks++;
    if (rl_addr[br % 16] !== 32'h1000 || rl_bs[br % 16] !== 8'd1) begin
      failures++; $display("FAIL rd_launch got=%h/%h exp=1000/01", rl_addr[br % 16], rl_bs[br % 16]);
    end
    checks++; if (status_reg_out !== 8'h37) begin failures++; $display("FAIL rd_status got=%h exp=37", status_reg_out); end
    capture(v);
    checks++; if (v !== 36'hF_00000011) begin failures++; $display("FAIL rd_word0 got=%h exp=f00000011", v); end
    capture(v);
    checks++; if (v !== 36'hE_00000022) begin failures++; $display("FAIL rd_word1 got=%h exp=e00000022", v); end
    repeat (2) @(negedge JTCK);
    checks++; if (status_reg_out !== 8'h07) begin failures++; $display("FAIL rd_done_status got=%h exp=07", status_reg_out); end
    checks++; if (n_rl - br != 1) begin failures++; $display("FAIL rd_extra_launch got=%0d exp=1", n_rl - br); end
  endtask

  task automatic test_error_abort();
    int bw, bs, bl;
    cmd(4'h3, 32'd3); cmd(4'h8, 32'hB0);
    @(negedge JTCK);
    checks++; if (status_reg_out !== 8'h0F) begin failures++; $display("FAIL busy_status got=%h exp=0f", status_reg_out); end
    cmd(4'h1, 32'h2000);
    checks++; if (status_reg_out !== 8'h4F) begin failures++; $display("FAIL busy_addr_err got=%h exp=4f", status_reg_out); end
    cmd(4'hE, 32'h0);
    checks++; if (status_reg_out !== 8'h0F) begin failures++; $display("FAIL err_cleared got=%h exp=0f", status_reg_out); end
    cmd(4'hF, 32'h0);
    checks++; if (status_reg_out !== 8'h07) begin failures++; $display("FAIL abort_fill got=%h exp=07", status_reg_out); end
    switch_ready = 1'b0;
    cmd(4'h3, 32'd0);
    bw = n_wr; bs = n_sw; bl = n_la;
    cmd(4'h8, 32'hC0);
    repeat (4) @(negedge JTCK);
    checks++; if (status_reg_out !== 8'h8F) begin failures++; $display("FAIL pending_status got=%h exp=8f", status_reg_out); end
    cmd(4'hF, 32'h0);
    checks++; if (status_reg_out !== 8'h07) begin failures++; $display("FAIL abort_wait got=%h exp=07", status_reg_out); end
    switch_ready = 1'b1;
    repeat (6) @(negedge JTCK);
    checks++;
    if (n_sw != bs || n_la != bl) begin
      failures++; $display("FAIL abort_no_pulse got=%0d/%0d exp=0/0", n_sw - bs, n_la - bl);
    end
    cmd(4'h8, 32'hD0);
    repeat (8) @(negedge JTCK);
    checks++; if (n_wr - bw != 2) begin failures++; $display("FAIL post_abort_wr_count got=%0d exp=2", n_wr - bw); end
    checks++;
    if (wr_addr[(bw + 1) % 64] !== 3'd0 || wr_data[(bw + 1) % 64] !== 32'hD0) begin
      failures++; $display("FAIL post_abort_word got=%h:%h exp=0:d0", wr_addr[(bw + 1) % 64], wr_data[(bw + 1) % 64]);
    end
    checks++;
    if (n_la - bl != 1 || la_addr[bl % 16] !== 32'h1000 || la_bs[bl % 16] !== 8'd0) begin
      failures++; $display("FAIL post_abort_launch got=%0d:%h/%h exp=1:1000/00", n_la - bl, la_addr[bl % 16], la_bs[bl % 16]);
    end
    checks++; if (status_reg_out !== 8'h07) begin failures++; $display("FAIL post_abort_status got=%h exp=07", status_reg_out); end
  endtask

  initial begin
    JRST = 1'b1; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JCE1 = 1'b0; switch_ready = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    @(negedge JTCK);
    test_reset();
    test_write_burst();
    test_split();
    test_read();
    test_error_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/jtag_burst_chain.md
Name: jtag_burst_chain

Overview:
- Parametrised successor of the single-chain JTAG user-register controller (JCE1 chain).
- Decodes opcode-tagged JTAG shift words into address, byte-enable, burst-size and data commands.
- Streams write data into the ping-pong buffer and reads DMA results out of it.
- Bursts longer than the buffer are split automatically into buffer-sized DMA chunks with address advance.
- Adds abort, error flagging and a correctly incrementing buffer pointer.

Parameters:
DATA_W, 32, data word width in bits (multiple of 8)
ADDR_W, 32, DMA byte-address width
BUF_DEPTH, 256, words per ping-pong half (power of 2, >=2)
BURST_W, 8, burst-size field width; words = field+1
OPC_W, 4, opcode field width (LSBs of shift word)

Ports:
JTCK  in  1  sole clock
JRST  in  1  synchronous active-high reset
JTDI  in  1  serial data in
JSHIFT  in  1  shift enable (while JCE1)
JUPDATE  in  1  update strobe, decodes shift_reg opcode
JCE1  in  1  chain select; capture when !JSHIFT
JTD1  out  1  shift_reg[0]
pp_address  out  clog2(BUF_DEPTH)+1  buffer word address, MSB always 0
pp_writeEnable  out  1  buffer write strobe
pp_dataIn  out  DATA_W  buffer write data
pp_dataOut  in  DATA_W  buffer read data, 1-cycle latency
pp_switch  out  1  one-cycle buffer swap pulse
switch_ready  in  1  DMA side allows swap
dma_address  out  ADDR_W  chunk start byte address (valid during launch pulse, else 0)
dma_byte_enable  out  DATA_W/8  byte enables (valid during launch, else 0)
dma_burst_size  out  BURST_W  chunk words-1 (valid during launch, else 0)
dma_data_ready  out  1  write-chunk launch pulse
dma_readReady  out  1  read-chunk launch pulse
status_reg_out  out  8  status register

Behaviour:
- Reset: all registers 0; state IDLE; every output 0 except JTD1=shift_reg[0]=0.
- shift_reg width SR_W=DATA_W+OPC_W. JCE1&JSHIFT: shift right, JTDI enters MSB.
- JCE1&!JSHIFT capture:
  - status[5]=1: load {all-ones(OPC_W-1), more, read_data}, where more=(words remaining after this one); pulse shifted_out.
  - status[5]=0: load zero-extended status.
- Status bits: [0] addr valid, [1] BE valid, [2] size valid, [3] write busy, [4] read busy, [5] read data valid, [6] error (sticky), [7] chunk pending switch.
- JUPDATE opcodes on shift_reg[OPC_W-1:0]; payload is shift_reg[SR_W-1:OPC_W]:
  - 1/2/3 set address / BE / size; ignored and error set if [3]|[4].
  - 8 write data: requires [2:0]=111, no read busy, state IDLE; else error set and word dropped. Sets [3].
  - 9 start read: requires [2:0]=111 and not busy; else error. Sets [4].
  - A: clears [5].
  - E: clears error.
  - F abort: state IDLE, clear [3],[4],[5],[7], ptr=0. Overrides everything in same cycle.
  - Unknown opcodes: no effect.
- Simultaneous events: JUPDATE bit-sets/clears apply after FSM status updates (last-assignment wins).
- FSM states: IDLE, W_FILL, W_WAIT_SW, W_SWITCH, W_LAUNCH, R_LAUNCH, R_WAIT_SW, R_SWITCH, R_ASK, R_STORE, R_PRESENT.
- Write path:
  - Opcode 8 -> W_FILL next cycle: pp_writeEnable=1, pp_address=ptr, ptr++, remaining--.
  - Leave W_FILL to W_WAIT_SW if last word or ptr==BUF_DEPTH-1; else to IDLE.
  - W_WAIT_SW: wait for switch_ready; [7]=1 while waiting.
  - W_SWITCH: pp_switch pulse.
  - W_LAUNCH: dma_data_ready pulse, burst_size=chunk_words-1. Then chunk_addr += chunk_words*DATA_W/8 (wraps mod 2^ADDR_W), ptr=0, [7]=0; clear [3] if burst done.
- Read path:
  - Opcode 9 -> R_LAUNCH: dma_readReady pulse, chunk=min(remaining+1,BUF_DEPTH).
  - R_WAIT_SW waits for switch_ready -> R_SWITCH pulse -> R_ASK (pp_address=ptr) -> R_STORE (latch pp_dataOut, set [5]) -> R_PRESENT.
  - R_PRESENT on shifted_out: clear [5].
    - Burst done: clear [4], go IDLE.
    - Chunk exhausted: advance address, ptr=0, go R_LAUNCH.
    - Else: ptr++, go R_ASK.
- Max burst 2^BURST_W words. Mid-operation reset fully returns to IDLE; no DMA pulse is emitted.

Decomposition:
- Package jtag_chain_pkg: opcode constants, status-bit indices, FSM state encoding.
- Sub-module jtag_cmd_shifter (shift/capture/update-decode, emits per-opcode one-cycle strobes).
- Chunk/pointer FSM stays in the top.

Test Plan:
- Reset then capture -> status 0x00, JTD1 0.
- addr=0x1000, BE=0xF, size=3, four writes of 0xA0..0xA3 -> pp writes at addresses 0..3, one switch, dma_data_ready with addr 0x1000 and burst 3; [3] cleared.
- BUF_DEPTH=4, size=9, 10 writes -> three launches: (0x1000,3), (0x1010,3), (0x1020,1).
- Read size=1 with pp_dataOut 0x11,0x22 -> captures 0xF_00000011 (more=1), then 0xE_00000022; [4] cleared.
- Opcode 1 during write busy -> address unchanged, status[6]=1; opcode E clears it.
- Abort while in W_WAIT_SW -> IDLE, status [3],[7] cleared, no pp_switch or DMA pulse.
